// File: rtl/dpc_fifo_rd_stream.sv
// Read-side consumer of the DPC async pixel FIFO (rclk domain): pops pixels and
// re-times them into a valid/ready raster stream with x/y position and frame markers.
module dpc_fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 12
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             i_en,
    input  logic             i_soft_clr,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    input  logic [DSIZE-1:0] fifo_rdata,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [DSIZE-1:0] o_data,
    output logic [CW-1:0]    o_x,
    output logic [CW-1:0]    o_y,
    output logic             o_sof,
    output logic             o_eol,
    output logic             o_eof
);

    localparam logic [CW-1:0] X_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(IMG_H - 1);

    logic [DSIZE-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_cnt;
    logic             r_pend;
    logic [CW-1:0]    r_x;
    logic [CW-1:0]    r_y;

    logic [1:0]       w_used;
    logic             w_hs;
    logic [1:0]       w_cnt_nxt;

    // used counts the in-flight pixel too, so a pop is only issued when its
    // data is guaranteed a free skid slot one cycle later.
    assign w_used    = r_cnt + {1'b0, r_pend};
    assign o_valid   = (r_cnt != 2'd0);
    assign w_hs      = o_valid & o_ready;
    assign fifo_rinc = rrst_n & i_en & ~fifo_rempty & ~i_soft_clr &
                       ((w_used < 2'd2) | ((w_used == 2'd2) & w_hs));

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({r_pend, w_hs})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    assign o_data = r_mem[r_rd_ptr];
    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_sof  = o_valid & (r_x == '0) & (r_y == '0);
    assign o_eol  = o_valid & (r_x == X_LAST);
    assign o_eof  = o_eol & (r_y == Y_LAST);

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            // NOTE: the two skid entries are reset so o_data reads a defined 0 after reset.
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
            r_pend   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else if (i_soft_clr) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
            r_pend   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            r_pend <= fifo_rinc;
            if (r_pend) begin
                r_mem[r_wr_ptr] <= fifo_rdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_hs) begin
                r_rd_ptr <= ~r_rd_ptr;
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
            r_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst_n) begin
            assert (w_used <= 2'd2)
                else $error("skid buffer overflow: cnt=%0d pend=%0d", r_cnt, r_pend);
        end
    end

endmodule

// File: tb/tb_dpc_fifo_rd_stream.sv
// Directed bench for dpc_fifo_rd_stream: FIFO model feeds a scoreboard queue, and a
// negedge monitor compares every accepted pixel, its position and its markers.
module tb_dpc_fifo_rd_stream;

    localparam int DSIZE = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int CW    = 12;

    logic             rclk = 1'b0;
    logic             rrst_n;
    logic             i_en;
    logic             i_soft_clr;
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic [DSIZE-1:0] fifo_rdata = '0;
    logic             o_valid;
    logic             o_ready;
    logic [DSIZE-1:0] o_data;
    logic [CW-1:0]    o_x;
    logic [CW-1:0]    o_y;
    logic             o_sof;
    logic             o_eol;
    logic             o_eof;

    int checks   = 0;
    int failures = 0;

    dpc_fifo_rd_stream #(.DSIZE(DSIZE), .IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW)) dut (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .i_en        (i_en),
        .i_soft_clr  (i_soft_clr),
        .fifo_rempty (fifo_rempty),
        .fifo_rinc   (fifo_rinc),
        .fifo_rdata  (fifo_rdata),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_x         (o_x),
        .o_y         (o_y),
        .o_sof       (o_sof),
        .o_eol       (o_eol),
        .o_eof       (o_eof)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    // Source FIFO model with registered read data, plus the scoreboard queue.
    logic [DSIZE-1:0] fifo_q[$];
    logic [DSIZE-1:0] exp_q[$];
    int   loaded      = 0;
    int   popped      = 0;
    logic force_empty = 1'b0;
    logic pend_m      = 1'b0;

    assign fifo_rempty = force_empty | (popped >= loaded);

    always @(posedge rclk) begin
        pend_m <= (fifo_rinc === 1'b1);
        if (fifo_rinc === 1'b1) begin
            if (fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
            popped <= popped + 1;
        end
    end

    // Monitor: checks handshake accounting and compares each accepted pixel.
    int               mx = 0;
    int               my = 0;
    int               used_m;
    logic             mv;
    logic             hs_m;
    logic             exp_rinc;
    logic             prev_stall = 1'b0;
    logic [DSIZE-1:0] prev_d;
    logic [CW-1:0]    prev_x;
    logic [CW-1:0]    prev_y;
    logic [DSIZE-1:0] exp_d;

    always @(negedge rclk) begin
        if (rrst_n !== 1'b1) begin
            mx = 0;
            my = 0;
            prev_stall = 1'b0;
        end else begin
            used_m   = exp_q.size() - fifo_q.size();
            mv       = ((used_m - int'(pend_m)) != 0);
            hs_m     = mv & o_ready;
            exp_rinc = i_en & ~fifo_rempty & ~i_soft_clr &
                       ((used_m < 2) | ((used_m == 2) & hs_m));
            check("used_le_2", 32'(used_m <= 2), 32'd1);
            check("o_valid", 32'(o_valid), 32'(mv));
            check("fifo_rinc", 32'(fifo_rinc), 32'(exp_rinc));
            if (prev_stall) begin
                check("stall_data", 32'(o_data), 32'(prev_d));
                check("stall_x", 32'(o_x), 32'(prev_x));
                check("stall_y", 32'(o_y), 32'(prev_y));
            end
            if (i_soft_clr) begin
                for (int i = 0; i < used_m; i++) void'(exp_q.pop_front());
                mx = 0;
                my = 0;
                prev_stall = 1'b0;
            end else begin
                if (hs_m) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        exp_d = exp_q.pop_front();
                        check("data", 32'(o_data), 32'(exp_d));
                        check("x", 32'(o_x), 32'(mx));
                        check("y", 32'(o_y), 32'(my));
                        check("sof", 32'(o_sof), 32'(mx == 0 && my == 0));
                        check("eol", 32'(o_eol), 32'(mx == IMG_W - 1));
                        check("eof", 32'(o_eof), 32'(mx == IMG_W - 1 && my == IMG_H - 1));
                        if (mx == IMG_W - 1) begin
                            mx = 0;
                            my = (my == IMG_H - 1) ? 0 : my + 1;
                        end else begin
                            mx = mx + 1;
                        end
                    end
                end
                prev_stall = mv & ~o_ready;
                prev_d     = o_data;
                prev_x     = o_x;
                prev_y     = o_y;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   rem;
    bit   found;

    initial begin
        rrst_n     = 1'b0;
        i_en       = 1'b0;
        i_soft_clr = 1'b0;
        o_ready    = 1'b0;
        for (int i = 0; i < 256; i++) begin
            fifo_q.push_back(DSIZE'(i));
            exp_q.push_back(DSIZE'(i));
        end
        loaded = 256;

        // Reset
        repeat (3) tick();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_rinc", 32'(fifo_rinc), 32'd0);
        check("rst_x", 32'(o_x), 32'd0);
        check("rst_y", 32'(o_y), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        i_en = 1'b1;
        #1;
        check("rst_rinc_gated", 32'(fifo_rinc), 32'd0);
        i_en = 1'b0;
        tick();
        rrst_n  = 1'b1;
        o_ready = 1'b1;
        tick();

        // Streaming: latency and sustained throughput
        i_en = 1'b1;
        #1;
        check("first_pop", 32'(fifo_rinc), 32'd1);
        tick();
        check("lat_cycle1_valid", 32'(o_valid), 32'd0);
        tick();
        check("lat_cycle2_valid", 32'(o_valid), 32'd1);
        check("first_data", 32'(o_data), 32'h00);
        check("first_sof", 32'(o_sof), 32'd1);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("stream_valid", 32'(o_valid), 32'd1);
        end

        // Backpressure
        for (int i = 0; i < 60; i++) begin
            o_ready = (i < 4) ? pat[i] : 1'($urandom_range(0, 1));
            tick();
        end
        o_ready = 1'b1;
        repeat (3) tick();

        // Starvation
        force_empty = 1'b1;
        repeat (5) tick();
        check("starve_drained", 32'(o_valid), 32'd0);
        force_empty = 1'b0;
        repeat (4) tick();
        check("starve_resumed", 32'(o_valid), 32'd1);

        // Soft clear at x=2, y=1 while streaming
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (o_valid && mx == 2 && my == 1) found = 1'b1;
            else tick();
        end
        check("clr_reach_timeout", 32'(found), 32'd1);
        check("clr_pre_x", 32'(o_x), 32'd2);
        check("clr_pre_y", 32'(o_y), 32'd1);
        i_soft_clr = 1'b1;
        tick();
        i_soft_clr = 1'b0;
        check("clr_valid", 32'(o_valid), 32'd0);
        check("clr_x", 32'(o_x), 32'd0);
        check("clr_y", 32'(o_y), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (o_valid) found = 1'b1;
            else tick();
        end
        check("clr_resume_timeout", 32'(found), 32'd1);
        check("clr_next_sof", 32'(o_sof), 32'd1);

        // i_en dropped right after a pop: the in-flight pixel still emerges
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (fifo_rinc) found = 1'b1;
            else tick();
        end
        check("en_pop_timeout", 32'(found), 32'd1);
        tick();
        i_en = 1'b0;
        rem  = fifo_q.size();
        repeat (8) tick();
        check("en_no_new_pops", 32'(fifo_q.size()), 32'(rem));
        check("en_inflight_drained", 32'(exp_q.size()), 32'(fifo_q.size()));
        check("en_idle_valid", 32'(o_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
